// File: rtl/ariane_pkg.sv
// Shared types for the write-back path.
// Provides:
//   XLEN, TRANS_ID_BITS : datapath and scoreboard-ID widths
//   exception_t         : exception payload carried with every result
//   wb_src_e            : result-source numbering used by the arbiter
//   wb_entry_t          : one buffered write-back {trans_id, result, exception}
package ariane_pkg;

  localparam int XLEN          = 32;
  localparam int TRANS_ID_BITS = 4;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef enum logic [1:0] {
    WB_FLU   = 2'd0,
    WB_LOAD  = 2'd1,
    WB_STORE = 2'd2,
    WB_FPU   = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    exception_t               exception;
  } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source write-back buffer.
// Ports:
//   clk_i, rst_i   : clock, async active-high reset (empties the FIFO)
//   clr_i          : synchronous empty (flush/clear), wins over push/pop
//   push_i, data_i : enqueue request; ignored when full unless popped same cycle
//   pop_i          : dequeue head (only meaningful when not empty)
//   data_o         : head entry, forced to zero when empty
//   full_o, empty_o, count_o : occupancy status from registered state
module wb_src_fifo
  import ariane_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wb_entry_t                data_i,
  output wb_entry_t                data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clr_i;

  // Zero the head when empty so idle write-back ports read all-zero.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers results from NR_SRC functional units and
// forwards up to NR_WB_PORTS of them per cycle to the scoreboard.
// Ports:
//   clk_i, rst_i        : clock, async active-high reset
//   clr_i               : sync clear (flush + clear round-robin and overflow)
//   flush_i             : kill write-back this cycle, empty FIFOs next edge
//   src_*_i             : per-source result valid / id / data / exception
//   src_stall_o         : per-source back-pressure to issue
//   wb_*_o              : write-back ports, port 0 highest in scan order
//   overflow_o          : sticky, set when a push was dropped on a full FIFO
module wb_arbiter
  import ariane_pkg::*;
#(
  parameter int NR_SRC      = 4,
  parameter int NR_WB_PORTS = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      clr_i,
  input  logic                                      flush_i,
  input  logic [NR_SRC-1:0]                         src_valid_i,
  input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]      src_trans_id_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]               src_result_i,
  input  exception_t [NR_SRC-1:0]                   src_exception_i,
  output logic [NR_SRC-1:0]                         src_stall_o,
  output logic [NR_WB_PORTS-1:0]                    wb_valid_o,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_result_o,
  output exception_t [NR_WB_PORTS-1:0]              wb_exception_o,
  output logic                                      overflow_o
);

  localparam int RR_W  = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                               flush_all;
  logic [NR_SRC-1:0]                  push, pop, full, empty, drop;
  logic [NR_SRC-1:0][CNT_W-1:0]       count;
  wb_entry_t [NR_SRC-1:0]             head;

  logic [RR_W-1:0] rr_q, rr_d;
  logic            overflow_q, any_grant;
  int              idx, last_idx, port_cnt, nxt;

  // clr behaves as a flush for the data path.
  assign flush_all = flush_i | clr_i;

  for (genvar s = 0; s < NR_SRC; s++) begin : g_src
    wb_entry_t din;
    assign din.trans_id  = src_trans_id_i[s];
    assign din.result    = src_result_i[s];
    assign din.exception = src_exception_i[s];

    assign push[s] = src_valid_i[s] & ~flush_all;
    // A dropped push is one that finds the FIFO full with no pop to make room.
    assign drop[s] = push[s] & full[s] & ~pop[s];
    // Stall one entry early: issue sees the stall a cycle late.
    assign src_stall_o[s] = (count[s] >= CNT_W'(FIFO_DEPTH - 1));

    wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (flush_all),
      .push_i  (push[s]),
      .pop_i   (pop[s]),
      .data_i  (din),
      .data_o  (head[s]),
      .full_o  (full[s]),
      .empty_o (empty[s]),
      .count_o (count[s])
    );
  end

  // Round-robin scan starting at rr_q; the k-th non-empty source found goes
  // to port k. Each source is visited once, so it gets at most one port.
  always_comb begin
    pop            = '0;
    wb_valid_o     = '0;
    wb_trans_id_o  = '0;
    wb_result_o    = '0;
    wb_exception_o = '0;
    any_grant      = 1'b0;
    last_idx       = 0;
    port_cnt       = 0;
    idx            = 0;
    nxt            = 0;
    if (!flush_all) begin
      for (int k = 0; k < NR_SRC; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NR_SRC) idx = idx - NR_SRC;
        for (int s = 0; s < NR_SRC; s++) begin
          if (s == idx && !empty[s] && port_cnt < NR_WB_PORTS) begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
              if (p == port_cnt) begin
                wb_valid_o[p]     = 1'b1;
                wb_trans_id_o[p]  = head[s].trans_id;
                wb_result_o[p]    = head[s].result;
                wb_exception_o[p] = head[s].exception;
              end
            end
            pop[s]    = 1'b1;
            last_idx  = s;
            any_grant = 1'b1;
            port_cnt  = port_cnt + 1;
          end
        end
      end
    end
    nxt = last_idx + 1;
    if (nxt >= NR_SRC) nxt = 0;
    rr_d = RR_W'(nxt);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else if (clr_i) begin
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (any_grant) rr_q <= rr_d;
      if (|drop)     overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;

endmodule
